// File: rtl/count8_timer_ctrl_pkg.sv
// Shared encodings for the count8 interval timer controller.
// The FSM state encoding, terminal count and mode values live here for reuse.
package count8_timer_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2,
      StDone = 2'd3
   } state_t;

   localparam logic [7:0] TERM_CNT      = 8'hFF;
   localparam logic       MODE_ONESHOT  = 1'b0;
   localparam logic       MODE_PERIODIC = 1'b1;

   // Counter is loaded with -period so it reaches TERM_CNT after exactly period cycles.
   function automatic logic [7:0] load_value(input logic [7:0] per);
      return ~per + 8'd1;
   endfunction

endpackage

// File: rtl/count8_timer_ctrl_count8a.sv
// 8-bit loadable up-counter datapath; Load takes priority over En.
module count8a (
   input  logic       Clk,
   input  logic       Res,
   input  logic       En,
   input  logic       Load,
   input  logic [7:0] cnt_in,
   output logic [7:0] cnt
);

   logic [7:0] r_cnt;

   always_ff @(posedge Clk or posedge Res) begin
      if (Res) begin
         r_cnt <= 8'h00;
      end else if (Load) begin
         r_cnt <= cnt_in;
      end else if (En) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/count8_timer_ctrl.sv
// Programmable interval timer built around count8a: loads -period, counts up to FF,
// emits a tick, then reloads (periodic) or finishes with a done pulse (one-shot).
module count8_timer_ctrl
   import count8_timer_ctrl_pkg::*;
(
   input  logic       Clk,
   input  logic       Res,
   input  logic       start,
   input  logic       stop,
   input  logic       hold,
   input  logic       mode,
   input  logic [7:0] period,
   output logic       busy,
   output logic       tick,
   output logic       done,
   output logic [7:0] cnt
);

   state_t     r_state;
   logic [7:0] r_per;
   logic       r_mode;
   logic       r_busy;
   logic       r_done;

   logic       w_term;
   logic       w_load;
   logic       w_en;
   logic [7:0] w_cnt_in;
   logic [7:0] w_cnt;

   // Terminal count only counts while running, not held and not being aborted.
   always_comb begin
      w_term   = (r_state == StRun) && !stop && !hold && (w_cnt == TERM_CNT);
      w_load   = (r_state == StLoad) || (w_term && (r_mode == MODE_PERIODIC));
      w_en     = (r_state == StRun) && !stop && !hold && !w_term;
      w_cnt_in = load_value(r_per);
   end

   always_ff @(posedge Clk or posedge Res) begin
      if (Res) begin
         r_state <= StIdle;
         r_per   <= 8'h00;
         r_mode  <= MODE_ONESHOT;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (start && !stop) begin
                  r_per   <= period;
                  r_mode  <= mode;
                  r_state <= StLoad;
                  r_busy  <= 1'b1;
               end
            end
            StLoad: begin
               if (stop) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= StRun;
               end
            end
            StRun: begin
               if (stop) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else if (w_term && (r_mode == MODE_ONESHOT)) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   count8a u_count8a (
      .Clk    (Clk),
      .Res    (Res),
      .En     (w_en),
      .Load   (w_load),
      .cnt_in (w_cnt_in),
      .cnt    (w_cnt)
   );

   assign busy = r_busy;
   assign done = r_done;
   assign tick = w_term;
   assign cnt  = w_cnt;

endmodule

// File: tb/tb_count8_timer_ctrl.sv
// Scoreboard bench for count8_timer_ctrl: stimulus queues expected events/snapshots,
// a negedge monitor matches them against the DUT outputs.
module tb_count8_timer_ctrl;

   logic       clk = 1'b0;
   logic       res;
   logic       start;
   logic       stop;
   logic       hold;
   logic       mode;
   logic [7:0] period;
   logic       busy;
   logic       tick;
   logic       done;
   logic [7:0] cnt;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         c;
      logic       b;
      logic       t;
      logic       d;
      logic [7:0] v;
   } snap_t;

   typedef struct {
      int k;   // 0 = tick, 1 = done
      int c;
   } ev_t;

   snap_t snap_q[$];
   ev_t   ev_q[$];

   count8_timer_ctrl dut (
      .Clk    (clk),
      .Res    (res),
      .start  (start),
      .stop   (stop),
      .hold   (hold),
      .mode   (mode),
      .period (period),
      .busy   (busy),
      .tick   (tick),
      .done   (done),
      .cnt    (cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endfunction

   function automatic void snap(input int c, input logic b, input logic t, input logic d,
                                input logic [7:0] v);
      snap_t s;
      s.c = c; s.b = b; s.t = t; s.d = d; s.v = v;
      snap_q.push_back(s);
   endfunction

   function automatic void ev(input int k, input int c);
      ev_t e;
      e.k = k; e.c = c;
      ev_q.push_back(e);
   endfunction

   function automatic void match_ev(input int k);
      ev_t e;
      if (ev_q.size() == 0) begin
         check((k != 0) ? "unexpected_done" : "unexpected_tick", 1, 0);
      end else begin
         e = ev_q.pop_front();
         check((k != 0) ? "done_kind" : "tick_kind", k, e.k);
         check((k != 0) ? "done_cycle" : "tick_cycle", cyc, e.c);
      end
   endfunction

   // Monitor
   always @(negedge clk) begin
      ev_t e;
      if (ev_q.size() > 0 && ev_q[0].c < cyc) begin
         e = ev_q.pop_front();
         check((e.k != 0) ? "missing_done" : "missing_tick", cyc, e.c);
      end
      if (tick) match_ev(0);
      if (done) match_ev(1);
      for (int i = snap_q.size() - 1; i >= 0; i--) begin
         if (snap_q[i].c == cyc) begin
            check("busy", int'(busy), int'(snap_q[i].b));
            check("tick", int'(tick), int'(snap_q[i].t));
            check("done", int'(done), int'(snap_q[i].d));
            check("cnt", int'(cnt), int'(snap_q[i].v));
            snap_q.delete(i);
         end
      end
   end

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic m, input logic [7:0] p);
      start  = 1'b1;
      mode   = m;
      period = p;
      goto(cyc + 1);
      start  = 1'b0;
   endtask

   initial begin
      int n0;
      res = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0; period = 8'd0;
      snap(1, 1'b0, 1'b0, 1'b0, 8'h00);
      goto(3);
      res = 1'b0;

      // Reset asserted mid-RUN at cnt = 37
      n0 = 5;
      goto(n0);
      snap(n0 + 2,  1'b1, 1'b0, 1'b0, 8'h00);
      snap(n0 + 56, 1'b1, 1'b0, 1'b0, 8'h36);
      snap(n0 + 57, 1'b0, 1'b0, 1'b0, 8'h00);
      snap(n0 + 58, 1'b0, 1'b0, 1'b0, 8'h00);
      snap(n0 + 59, 1'b0, 1'b0, 1'b0, 8'h00);
      pulse(1'b0, 8'd0);
      goto(n0 + 57);
      res = 1'b1;
      goto(n0 + 58);
      res = 1'b0;

      // One-shot, period 5
      n0 = cyc + 2;
      goto(n0);
      snap(n0 + 2, 1'b1, 1'b0, 1'b0, 8'hFB);
      snap(n0 + 3, 1'b1, 1'b0, 1'b0, 8'hFC);
      snap(n0 + 4, 1'b1, 1'b0, 1'b0, 8'hFD);
      snap(n0 + 5, 1'b1, 1'b0, 1'b0, 8'hFE);
      snap(n0 + 6, 1'b1, 1'b1, 1'b0, 8'hFF);
      snap(n0 + 7, 1'b1, 1'b0, 1'b1, 8'hFF);
      snap(n0 + 8, 1'b0, 1'b0, 1'b0, 8'hFF);
      ev(0, n0 + 6);
      ev(1, n0 + 7);
      pulse(1'b0, 8'd5);
      goto(n0 + 10);

      // Periodic, period 3, then stop
      n0 = cyc + 2;
      goto(n0);
      for (int i = 0; i < 4; i++) ev(0, n0 + 4 + 3 * i);
      snap(n0 + 5,  1'b1, 1'b0, 1'b0, 8'hFD);
      snap(n0 + 6,  1'b1, 1'b0, 1'b0, 8'hFE);
      snap(n0 + 7,  1'b1, 1'b1, 1'b0, 8'hFF);
      snap(n0 + 15, 1'b0, 1'b0, 1'b0, 8'hFD);
      pulse(1'b1, 8'd3);
      goto(n0 + 14);
      stop = 1'b1;
      goto(n0 + 15);
      stop = 1'b0;
      goto(n0 + 17);

      // Periodic, period 1: tick every cycle
      n0 = cyc + 2;
      goto(n0);
      for (int i = 2; i <= 6; i++) ev(0, n0 + i);
      snap(n0 + 3, 1'b1, 1'b1, 1'b0, 8'hFF);
      snap(n0 + 7, 1'b1, 1'b0, 1'b0, 8'hFF);
      snap(n0 + 8, 1'b0, 1'b0, 1'b0, 8'hFF);
      pulse(1'b1, 8'd1);
      goto(n0 + 7);
      stop = 1'b1;
      goto(n0 + 8);
      stop = 1'b0;
      goto(n0 + 10);

      // One-shot, period 0 means 256
      n0 = cyc + 2;
      goto(n0);
      snap(n0 + 2,   1'b1, 1'b0, 1'b0, 8'h00);
      snap(n0 + 100, 1'b1, 1'b0, 1'b0, 8'h62);
      snap(n0 + 257, 1'b1, 1'b1, 1'b0, 8'hFF);
      snap(n0 + 258, 1'b1, 1'b0, 1'b1, 8'hFF);
      snap(n0 + 259, 1'b0, 1'b0, 1'b0, 8'hFF);
      ev(0, n0 + 257);
      ev(1, n0 + 258);
      pulse(1'b0, 8'd0);
      goto(n0 + 261);

      // Hold for 3 cycles delays the tick; stop on cnt = FF suppresses it
      n0 = cyc + 2;
      goto(n0);
      snap(n0 + 2,  1'b1, 1'b0, 1'b0, 8'hFC);
      snap(n0 + 5,  1'b1, 1'b0, 1'b0, 8'hFD);
      snap(n0 + 6,  1'b1, 1'b0, 1'b0, 8'hFD);
      snap(n0 + 7,  1'b1, 1'b0, 1'b0, 8'hFE);
      snap(n0 + 8,  1'b1, 1'b1, 1'b0, 8'hFF);
      snap(n0 + 16, 1'b1, 1'b0, 1'b0, 8'hFF);
      snap(n0 + 17, 1'b0, 1'b0, 1'b0, 8'hFF);
      ev(0, n0 + 8);
      ev(0, n0 + 12);
      pulse(1'b1, 8'd4);
      goto(n0 + 3);
      hold = 1'b1;
      goto(n0 + 6);
      hold = 1'b0;
      goto(n0 + 16);
      stop = 1'b1;
      goto(n0 + 17);
      stop = 1'b0;
      goto(n0 + 19);

      // Start while running is ignored
      n0 = cyc + 2;
      goto(n0);
      for (int i = 0; i < 4; i++) ev(0, n0 + 4 + 3 * i);
      snap(n0 + 8,  1'b1, 1'b0, 1'b0, 8'hFD);
      snap(n0 + 15, 1'b0, 1'b0, 1'b0, 8'hFD);
      pulse(1'b1, 8'd3);
      goto(n0 + 5);
      start  = 1'b1;
      mode   = 1'b0;
      period = 8'd7;
      goto(n0 + 6);
      start  = 1'b0;
      goto(n0 + 14);
      stop = 1'b1;
      goto(n0 + 15);
      stop = 1'b0;
      goto(n0 + 17);

      // start and stop together in IDLE
      n0 = cyc + 2;
      goto(n0);
      snap(n0 + 1, 1'b0, 1'b0, 1'b0, 8'hFD);
      snap(n0 + 2, 1'b0, 1'b0, 1'b0, 8'hFD);
      start  = 1'b1;
      stop   = 1'b1;
      mode   = 1'b1;
      period = 8'd9;
      goto(n0 + 1);
      start = 1'b0;
      stop  = 1'b0;
      goto(n0 + 5);

      check("pending_events", ev_q.size(), 0);
      check("pending_snapshots", snap_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
